// File: rtl/riscv_multi_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Optional memory wait states: RISCV_MULTI_CTRL_MEM_WAIT_EN
module riscv_multi_ctrl #(
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
`ifdef RISCV_MULTI_CTRL_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_we,
  output logic       ir_we,
  output logic       adr_src,
  output logic       mem_we,
  output logic       reg_we,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic [1:0] res_src,
  output logic       halted
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_HALT
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       f7_q;
  logic       rdy;
  logic       f3_ok;
  state_t     bad_n;

`ifdef RISCV_MULTI_CTRL_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  // SLTU is the one funct3 code this ALU cannot execute.
  assign f3_ok = (funct3 != 3'b011);
  assign bad_n = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;

  function automatic logic [3:0] alu_dec(
    input logic       is_r,
    input logic [2:0] f3,
    input logic       f7
  );
    logic [3:0] r;
    r = ALU_ADD;
    unique case (1'b1)
      (f3 == 3'b000): r = (is_r && f7) ? ALU_SUB : ALU_ADD;
      (f3 == 3'b100): r = ALU_XOR;
      (f3 == 3'b110): r = ALU_OR;
      (f3 == 3'b111): r = ALU_AND;
      (f3 == 3'b010): r = ALU_SLT;
      (f3 == 3'b001): r = ALU_SLL;
      (f3 == 3'b101): r = f7 ? ALU_SRA : ALU_SRL;
      default:        r = ALU_ADD;
    endcase
    return r;
  endfunction

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_n;
  end

  // Capture instruction fields in DECODE for later states.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q <= '0;
      f3_q <= '0;
      f7_q <= 1'b0;
    end else if (state == S_DECODE) begin
      op_q <= op;
      f3_q <= funct3;
      f7_q <= funct7b5;
    end
  end

  // Next-state and Moore outputs; everything is quiet while in reset.
  always_comb begin
    state_n   = state;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    adr_src   = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    imm_src   = IMM_I;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_ctrl  = ALU_ADD;
    res_src   = 2'b00;
    halted    = 1'b0;
    if (rst) begin
      unique case (state)
        S_FETCH: begin
          pc_we     = rdy;
          ir_we     = rdy;
          alu_src_b = 2'b10;
          res_src   = 2'b10;
          state_n   = rdy ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          imm_src   = IMM_B;
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          case (op)
            OP_LW, OP_SW: state_n = S_MEM_ADR;
            OP_R:   state_n = f3_ok ? S_EXEC_R : bad_n;
            OP_I:   state_n = f3_ok ? S_EXEC_I : bad_n;
            OP_BR:  state_n = S_BRANCH;
            OP_JAL: state_n = S_JAL;
            default: state_n = bad_n;
          endcase
        end
        S_MEM_ADR: begin
          imm_src   = (op_q == OP_SW) ? IMM_S : IMM_I;
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          state_n   = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          adr_src = 1'b1;
          state_n = rdy ? S_MEM_WB : S_MEM_READ;
        end
        S_MEM_WB: begin
          res_src = 2'b01;
          reg_we  = 1'b1;
          state_n = S_FETCH;
        end
        S_MEM_WRITE: begin
          adr_src = 1'b1;
          mem_we  = rdy;
          state_n = rdy ? S_FETCH : S_MEM_WRITE;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_ctrl  = alu_dec(1'b1, f3_q, f7_q);
          state_n   = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_ctrl  = alu_dec(1'b0, f3_q, f7_q);
          state_n   = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_we  = 1'b1;
          state_n = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 2'b10;
          alu_ctrl  = ALU_SUB;
          pc_we     = zero && (f3_q == 3'b000);
          state_n   = S_FETCH;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_we     = 1'b1;
          state_n   = S_ALU_WB;
        end
        S_HALT: begin
          halted  = 1'b1;
          state_n = S_HALT;
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// Scoreboard bench for riscv_multi_ctrl, both trap settings.
// Reference expectations come from per-instruction phase lists.
module tb_riscv_multi_ctrl;

  localparam logic [3:0] A_ADD = 4'd0;
  localparam logic [3:0] A_SUB = 4'd1;
  localparam logic [3:0] A_AND = 4'd2;
  localparam logic [3:0] A_OR  = 4'd3;
  localparam logic [3:0] A_XOR = 4'd4;
  localparam logic [3:0] A_SLT = 4'd5;
  localparam logic [3:0] A_SLL = 4'd6;
  localparam logic [3:0] A_SRL = 4'd7;
  localparam logic [3:0] A_SRA = 4'd8;

  typedef enum int {
    P_F, P_D, P_MA, P_MR, P_MW, P_MWB,
    P_ER, P_EI, P_AWB, P_BR, P_J, P_H, P_RST
  } ph_t;

  typedef struct packed {
    logic [18:0] e1;
    logic [18:0] e2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
`ifdef RISCV_MULTI_CTRL_MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif

  logic       pc_we1, ir_we1, adr_src1, mem_we1, reg_we1, halted1;
  logic [2:0] imm_src1;
  logic [1:0] a1, b1, res1;
  logic [3:0] alu1;
  logic       pc_we2, ir_we2, adr_src2, mem_we2, reg_we2, halted2;
  logic [2:0] imm_src2;
  logic [1:0] a2, b2, res2;
  logic [3:0] alu2;

  logic [18:0] got1, got2;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic       cur_z;

  always #5 clk = ~clk;

  riscv_multi_ctrl #(.ILLEGAL_TRAP(1)) u_trap (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7b5(funct7b5),
`ifdef RISCV_MULTI_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .zero(zero),
    .pc_we(pc_we1), .ir_we(ir_we1), .adr_src(adr_src1),
    .mem_we(mem_we1), .reg_we(reg_we1), .imm_src(imm_src1),
    .alu_src_a(a1), .alu_src_b(b1), .alu_ctrl(alu1),
    .res_src(res1), .halted(halted1)
  );

  riscv_multi_ctrl #(.ILLEGAL_TRAP(0)) u_nop (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7b5(funct7b5),
`ifdef RISCV_MULTI_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .zero(zero),
    .pc_we(pc_we2), .ir_we(ir_we2), .adr_src(adr_src2),
    .mem_we(mem_we2), .reg_we(reg_we2), .imm_src(imm_src2),
    .alu_src_a(a2), .alu_src_b(b2), .alu_ctrl(alu2),
    .res_src(res2), .halted(halted2)
  );

  assign got1 = {pc_we1, ir_we1, adr_src1, mem_we1, reg_we1,
                 imm_src1, a1, b1, alu1, res1, halted1};
  assign got2 = {pc_we2, ir_we2, adr_src2, mem_we2, reg_we2,
                 imm_src2, a2, b2, alu2, res2, halted2};

  function automatic logic [18:0] pk(
    input logic pcw, input logic irw, input logic ads,
    input logic mw, input logic rw, input logic [2:0] imm,
    input logic [1:0] a, input logic [1:0] b,
    input logic [3:0] alu, input logic [1:0] res, input logic h
  );
    return {pcw, irw, ads, mw, rw, imm, a, b, alu, res, h};
  endfunction

  function automatic logic [3:0] ref_alu(
    input logic is_r, input logic [2:0] f3, input logic f7
  );
    logic [3:0] tbl [8];
    logic [3:0] r;
    tbl = '{A_ADD, A_SLL, A_SLT, A_ADD, A_XOR, A_SRL, A_OR, A_AND};
    r = tbl[f3];
    if (f3 == 3'b000 && is_r && f7) r = A_SUB;
    if (f3 == 3'b101 && f7) r = A_SRA;
    return r;
  endfunction

  function automatic logic [18:0] exp_of(input ph_t p, input logic rdy);
    logic [18:0] e;
    e = '0;
    case (p)
      P_F:   e = pk(rdy, rdy, 0, 0, 0, 3'd0, 2'd0, 2'd2, A_ADD, 2'd2, 0);
      P_D:   e = pk(0, 0, 0, 0, 0, 3'd2, 2'd1, 2'd1, A_ADD, 2'd0, 0);
      P_MA:  e = pk(0, 0, 0, 0, 0, (cur_op == 7'b0100011) ? 3'd1 : 3'd0,
                    2'd2, 2'd1, A_ADD, 2'd0, 0);
      P_MR:  e = pk(0, 0, 1, 0, 0, 3'd0, 2'd0, 2'd0, A_ADD, 2'd0, 0);
      P_MW:  e = pk(0, 0, 1, rdy, 0, 3'd0, 2'd0, 2'd0, A_ADD, 2'd0, 0);
      P_MWB: e = pk(0, 0, 0, 0, 1, 3'd0, 2'd0, 2'd0, A_ADD, 2'd1, 0);
      P_ER:  e = pk(0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd0,
                    ref_alu(1'b1, cur_f3, cur_f7), 2'd0, 0);
      P_EI:  e = pk(0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd1,
                    ref_alu(1'b0, cur_f3, cur_f7), 2'd0, 0);
      P_AWB: e = pk(0, 0, 0, 0, 1, 3'd0, 2'd0, 2'd0, A_ADD, 2'd0, 0);
      P_BR:  e = pk(cur_z && cur_f3 == 3'b000, 0, 0, 0, 0, 3'd0,
                    2'd2, 2'd0, A_SUB, 2'd0, 0);
      P_J:   e = pk(1, 0, 0, 0, 0, 3'd0, 2'd1, 2'd2, A_ADD, 2'd0, 0);
      P_H:   e = pk(0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd0, A_ADD, 2'd0, 1);
      default: e = '0;
    endcase
    return e;
  endfunction

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (got1 !== e.e1) begin
        n_fail++;
        $display("FAIL trap_dut cyc=%0d got=%05h expected=%05h",
                 cyc, got1, e.e1);
      end
      n_chk++;
      if (got2 !== e.e2) begin
        n_fail++;
        $display("FAIL nop_dut cyc=%0d got=%05h expected=%05h",
                 cyc, got2, e.e2);
      end
    end
  end

  task automatic step(input ph_t p1, input ph_t p2,
                      input logic rdy, input logic rv);
    exp_t e;
    rst = rv;
`ifdef RISCV_MULTI_CTRL_MEM_WAIT_EN
    mem_ready = rdy;
`endif
    e.e1 = rv ? exp_of(p1, rdy) : '0;
    e.e2 = rv ? exp_of(p2, rdy) : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(P_RST, P_RST, 1'b1, 1'b0);
    step(P_RST, P_RST, 1'b1, 1'b0);
  endtask

  task automatic do_phase(input ph_t p, input int forced_wait);
    int n;
    n = 0;
`ifdef RISCV_MULTI_CTRL_MEM_WAIT_EN
    if (p == P_F || p == P_MR || p == P_MW)
      n = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
`endif
    for (int k = 0; k < n; k++) step(p, p, 1'b0, 1'b1);
    step(p, p, 1'b1, 1'b1);
  endtask

  task automatic run_insn(input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic z,
                          input int rst_at, input int mw_wait);
    ph_t path[$];
    logic legal;
    cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_z = z;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    case (o)
      7'b0000011: path = '{P_F, P_D, P_MA, P_MR, P_MWB};
      7'b0100011: path = '{P_F, P_D, P_MA, P_MW};
      7'b0110011: path = '{P_F, P_D, P_ER, P_AWB};
      7'b0010011: path = '{P_F, P_D, P_EI, P_AWB};
      7'b1100011: path = '{P_F, P_D, P_BR};
      7'b1101111: path = '{P_F, P_D, P_J, P_AWB};
      default:    path = '{};
    endcase
    legal = (path.size() > 0);
    if ((o == 7'b0110011 || o == 7'b0010011) && f3 == 3'b011)
      legal = 1'b0;
    if (!legal) begin
      do_phase(P_F, -1);
      step(P_D, P_D, 1'b1, 1'b1);
      for (int k = 0; k < 10; k++)
        step(P_H, (k % 2 == 0) ? P_F : P_D, 1'b1, 1'b1);
      do_reset();
      return;
    end
    foreach (path[i]) begin
      if (i == rst_at) begin
        do_reset();
        return;
      end
      do_phase(path[i], (path[i] == P_MW) ? mw_wait : -1);
    end
  endtask

  function automatic logic [6:0] rand_op(input int cls);
    logic [6:0] o;
    case (cls)
      0: o = 7'b0000011;
      1: o = 7'b0100011;
      2, 3: o = 7'b0110011;
      4, 5: o = 7'b0010011;
      6: o = 7'b1100011;
      7: o = 7'b1101111;
      default: begin
        o = 7'($urandom);
        if (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
            o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111)
          o = 7'b1111111;
      end
    endcase
    return o;
  endfunction

  initial begin
    cur_op = '0; cur_f3 = '0; cur_f7 = 1'b0; cur_z = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    run_insn(7'b0000011, 3'b010, 1'b0, 1'b0, 3, -1);
    run_insn(7'b0110011, 3'b100, 1'b0, 1'b0, -1, -1);
    run_insn(7'b0110011, 3'b000, 1'b1, 1'b0, -1, -1);
    run_insn(7'b0010011, 3'b101, 1'b1, 1'b0, -1, -1);
    run_insn(7'b0000011, 3'b010, 1'b0, 1'b0, -1, -1);
    run_insn(7'b1100011, 3'b000, 1'b0, 1'b1, -1, -1);
    run_insn(7'b1100011, 3'b000, 1'b0, 1'b0, -1, -1);
    run_insn(7'b1100011, 3'b001, 1'b0, 1'b1, -1, -1);
    run_insn(7'b1101111, 3'b000, 1'b0, 1'b0, -1, -1);
    run_insn(7'b0100011, 3'b010, 1'b0, 1'b0, -1, 3);
    run_insn(7'b1111111, 3'b000, 1'b0, 1'b0, -1, -1);
    run_insn(7'b0110011, 3'b011, 1'b0, 1'b0, -1, -1);
    for (int n = 0; n < 80; n++) begin
      int cls;
      int ra;
      cls = int'($urandom_range(0, 9));
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_insn(rand_op(cls), 3'($urandom), 1'($urandom),
               1'($urandom), ra, -1);
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
